// File: rtl/sw_driver_pkg.sv
// sw_driver_pkg: shared FSM state type and SW bus bit positions for the picoMIPS switch driver.
package sw_driver_pkg;
    typedef enum logic [2:0] {
        IDLE,
        CPU_RST,
        PRESENT,
        STROBE_HI,
        STROBE_LO,
        WAIT_RES,
        CAPTURE
    } state_t;
    localparam int SW_NRESET = 9;
    localparam int SW_STROBE = 8;
endpackage

// File: rtl/sw_fifo.sv
// sw_fifo: circular operand buffer with an occupancy count.
// Ports: clk, Reset (sync, active-high), push/wdata (write), pop (read),
// rdata (combinational head), full, empty.
module sw_fifo #(
    parameter int n     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         push,
    input  logic         pop,
    input  logic [n-1:0] wdata,
    output logic [n-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [n-1:0]  mem [DEPTH];
    logic [AW-1:0] rp, wp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push while full still lands
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp];
    always_ff @(posedge clk) begin
        if (Reset) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + AW'(1);
            end
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sw_stimulus_driver.sv
// sw_stimulus_driver: buffers operands, resets the picoMIPS, strobes each operand onto SW and captures LED.
// Ports: clk, Reset (sync, active-high); wr_en/wr_data/full (operand FIFO);
// start/busy (run control); SW[9]=nReset, SW[8]=strobe, SW[n-1:0]=operand;
// LED (CPU result in); result/result_valid (captured LED, one-cycle pulse).
module sw_stimulus_driver
    import sw_driver_pkg::*;
#(
    parameter int n           = 8,
    parameter int DEPTH       = 4,
    parameter int RST_CYCLES  = 4,
    parameter int HOLD        = 4,
    parameter int GAP         = 4,
    parameter int RESULT_WAIT = 16
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         wr_en,
    input  logic [n-1:0] wr_data,
    output logic         full,
    input  logic         start,
    output logic         busy,
    output logic [9:0]   SW,
    input  logic [n-1:0] LED,
    output logic [n-1:0] result,
    output logic         result_valid
);
    localparam int M1   = RST_CYCLES > HOLD ? RST_CYCLES : HOLD;
    localparam int M2   = GAP > RESULT_WAIT ? GAP : RESULT_WAIT;
    localparam int MAXC = M1 > M2 ? M1 : M2;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;

    state_t        st, nxt;
    logic [CW-1:0] cnt, cnt_d, load;
    logic          cnt_z, empty;
    logic [n-1:0]  head;
    logic [9:0]    sw_d;

    sw_fifo #(.n(n), .DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .Reset(Reset),
        .push (wr_en),
        .pop  (st == PRESENT),
        .wdata(wr_data),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    assign cnt_z = cnt == '0;

    always_comb begin
        nxt = st;
        case (st)
            IDLE:               nxt = start ? CPU_RST : IDLE;
            CPU_RST, STROBE_LO: if (cnt_z) nxt = empty ? WAIT_RES : PRESENT;
            PRESENT:            nxt = STROBE_HI;
            STROBE_HI:          if (cnt_z) nxt = STROBE_LO;
            WAIT_RES:           if (cnt_z) nxt = CAPTURE;
            CAPTURE:            nxt = IDLE;
            default:            nxt = IDLE;
        endcase
    end

    // registered outputs are computed from the next state so they line up with the state register
    always_comb begin
        load  = nxt == CPU_RST   ? CW'(RST_CYCLES - 1) :
                nxt == STROBE_HI ? CW'(HOLD - 1) :
                nxt == STROBE_LO ? CW'(GAP - 1) :
                nxt == WAIT_RES  ? CW'(RESULT_WAIT - 1) : '0;
        cnt_d = nxt != st ? load : cnt_z ? cnt : cnt - CW'(1);
        sw_d  = '0;
        sw_d[SW_NRESET] = nxt != CPU_RST;
        sw_d[SW_STROBE] = nxt == STROBE_HI;
        // head is latched on entry to PRESENT; the pop itself happens during PRESENT
        sw_d[n-1:0]     = (nxt == IDLE || nxt == CPU_RST) ? '0 :
                          nxt == PRESENT ? head : SW[n-1:0];
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            st           <= IDLE;
            cnt          <= '0;
            SW           <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            st           <= nxt;
            cnt          <= cnt_d;
            SW           <= sw_d;
            busy         <= nxt != IDLE;
            result_valid <= nxt == CAPTURE;
            if (nxt == CAPTURE) result <= LED;
        end
    end
endmodule

// File: tb/tb_sw_stimulus_driver.sv
// tb_sw_stimulus_driver: scoreboard bench for sw_stimulus_driver; a negedge monitor checks SW timing, operands and results.
module tb_sw_stimulus_driver;
    localparam int N           = 8;
    localparam int DEPTH       = 4;
    localparam int RST_CYCLES  = 4;
    localparam int HOLD        = 4;
    localparam int GAP         = 4;
    localparam int RESULT_WAIT = 16;

    logic         clk = 1'b0, Reset = 1'b1, wr_en = 1'b0, start = 1'b0;
    logic [N-1:0] wr_data = '0, LED = '0;
    logic         full, busy, result_valid;
    logic [9:0]   SW;
    logic [N-1:0] result;

    always #5 clk = ~clk;

    sw_stimulus_driver #(
        .n(N), .DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES), .HOLD(HOLD), .GAP(GAP), .RESULT_WAIT(RESULT_WAIT)
    ) dut (
        .clk(clk), .Reset(Reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .start(start), .busy(busy), .SW(SW), .LED(LED), .result(result), .result_valid(result_valid)
    );

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } dchk_t;

    dchk_t dq[$];
    int    exp_ops[$];
    int    exp_res[$];
    int    mq[$];
    int    n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    int         cyc = 0, low_cnt = 0, hi_cnt = 0, last_evt = 0, last_kind = 0, act = 0, op = 0;
    logic [9:0] prev_sw = '0;
    logic       prev_rv = 1'b0;
    dchk_t      d;

    always @(negedge clk) begin
        cyc++;
        while (dq.size() > 0) begin
            d = dq.pop_front();
            case (d.sel)
                0:       act = int'(SW);
                1:       act = int'(busy);
                2:       act = int'(full);
                3:       act = int'(result);
                4:       act = int'(result_valid);
                5:       act = exp_res.size();
                6:       act = exp_ops.size();
                default: act = int'(SW[8]);
            endcase
            chk(d.name, act, d.exp);
        end
        if (Reset) begin
            low_cnt   = 0;
            hi_cnt    = 0;
            last_kind = 0;
        end else begin
            if (busy && !SW[9]) low_cnt++;
            if (SW[9] && !prev_sw[9] && low_cnt != 0) begin
                chk("cpu_reset_len", low_cnt, RST_CYCLES);
                low_cnt   = 0;
                last_evt  = cyc;
                last_kind = 1;
            end
            if (SW[8] && !prev_sw[8]) begin
                chk("strobe_setup", int'(prev_sw[7:0] == SW[7:0] && prev_sw[9] && !prev_sw[8]), 1);
                chk("strobe_spacing", cyc - last_evt, last_kind == 1 ? 1 : GAP + 1);
                chk("operand_expected", int'(exp_ops.size() != 0), 1);
                op = exp_ops.size() != 0 ? exp_ops.pop_front() : -1;
                chk("operand", int'(SW[7:0]), op);
                hi_cnt = 0;
            end
            if (SW[8] && prev_sw[8]) chk("operand_hold", int'(SW[7:0]), int'(prev_sw[7:0]));
            if (SW[8]) hi_cnt++;
            if (!SW[8] && prev_sw[8]) begin
                chk("strobe_len", hi_cnt, HOLD);
                last_evt  = cyc;
                last_kind = 2;
            end
            if (result_valid) begin
                chk("result_pulse_width", int'(prev_rv), 0);
                chk("result_expected", int'(exp_res.size() != 0), 1);
                chk("result_delay", cyc - last_evt, last_kind == 2 ? GAP + RESULT_WAIT : RESULT_WAIT);
                chk("result", int'(result), exp_res.size() != 0 ? exp_res.pop_front() : -1);
                chk("operands_consumed", exp_ops.size(), 0);
            end
        end
        prev_sw = SW;
        prev_rv = result_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_(input string nm, input int sel, input int exp);
        dq.push_back('{nm, sel, exp});
    endtask

    task automatic push_op(input int v);
        wr_en   = 1'b1;
        wr_data = N'(v);
        tick();
        wr_en = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(v & 8'hff);
    endtask

    task automatic begin_run(input int led);
        LED = N'(led);
        exp_res.push_back(led & 8'hff);
        while (mq.size() > 0) exp_ops.push_back(mq.pop_front());
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_run();
        for (int i = 0; i < 400 && busy; i++) tick();
        expect_("run_finished", 1, 0);
        tick();
    endtask

    task automatic wait_strobe();
        for (int i = 0; i < 100 && !SW[8]; i++) tick();
        expect_("strobe_seen", 7, 1);
    endtask

    initial begin
        repeat (3) tick();
        expect_("reset_sw", 0, 0);
        expect_("reset_busy", 1, 0);
        expect_("reset_result", 3, 0);
        expect_("reset_valid", 4, 0);
        expect_("reset_full", 2, 0);
        tick();
        Reset = 1'b0;
        tick();
        tick();
        expect_("idle_sw", 0, 10'h200);

        push_op(8'h05);
        push_op(8'h03);
        begin_run(8'h0F);
        finish_run();
        repeat (5) tick();
        expect_("result_held", 3, 8'h0F);

        for (int i = 0; i < 5; i++) begin
            push_op(int'($urandom_range(0, 255)));
            expect_("full_flag", 2, int'(mq.size() == DEPTH));
        end
        begin_run(int'($urandom_range(0, 255)));
        finish_run();
        expect_("full_after_run", 2, 0);

        push_op(8'h11);
        begin_run(8'h5A);
        wait_strobe();
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        exp_ops.push_back(8'hAA);
        finish_run();

        begin_run(8'h80);
        finish_run();
        expect_("empty_run_idle", 1, 0);

        push_op(8'h21);
        begin_run(8'h42);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_run();
        repeat (30) tick();
        expect_("no_second_run", 1, 0);

        Reset = 1'b1;
        start = 1'b1;
        tick();
        Reset = 1'b0;
        start = 1'b0;
        tick();
        expect_("reset_start_busy", 1, 0);
        expect_("reset_start_sw", 0, 10'h200);
        repeat (30) tick();
        expect_("reset_start_idle", 1, 0);

        push_op(8'h71);
        push_op(8'h72);
        begin_run(8'h33);
        wait_strobe();
        Reset = 1'b1;
        tick();
        expect_("abort_sw", 0, 0);
        expect_("abort_busy", 1, 0);
        expect_("abort_result", 3, 0);
        expect_("abort_valid", 4, 0);
        exp_ops.delete();
        exp_res.delete();
        mq.delete();
        tick();
        Reset = 1'b0;
        tick();
        begin_run(8'h3C);
        finish_run();

        for (int r = 0; r < 8; r++) begin
            int k;
            k = int'($urandom_range(0, 6));
            for (int j = 0; j < k; j++) push_op(int'($urandom_range(0, 255)));
            expect_("rand_full", 2, int'(mq.size() == DEPTH));
            begin_run(int'($urandom_range(0, 255)));
            finish_run();
        end

        repeat (5) tick();
        expect_("leftover_results", 5, 0);
        expect_("leftover_operands", 6, 0);
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
